// File: rtl/bus_dma_pkg.sv
// bus_dma_pkg: constants and helpers shared by the bus_dma block and its
// environment.
//   WORD_STEP   - byte increment between consecutive 32-bit words
//   IO_IN_ADDR  - memory-mapped input register of the io responder
//   IO_OUT_ADDR - memory-mapped output register of the io responder
//   word_align  - forces a byte address onto a word boundary
package bus_dma_pkg;

    localparam logic [31:0] WORD_STEP   = 32'd4;
    localparam logic [31:0] IO_IN_ADDR  = 32'h0000_0000;
    localparam logic [31:0] IO_OUT_ADDR = 32'h0000_0004;

    // Clear the two byte-select bits; the block only moves whole words.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/bus_dma_if.sv
// bus_dma_if: groups the bus_dma request and memory-bus signals.
//   Request side : start, src, dst, len (in to DMA); busy, done (out of DMA)
//   Bus side     : bus_we, bus_addr, bus_wd (out of DMA); bus_rd (in to DMA)
//   Fill option  : fill, fill_val (present only when BUS_DMA_FILL_EN is defined)
// Modports: master = the DMA engine, slave = requester plus memory responder.
interface bus_dma_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             bus_we;
    logic [31:0]      bus_addr;
    logic [31:0]      bus_wd;
    logic [31:0]      bus_rd;
`ifdef BUS_DMA_FILL_EN
    logic             fill;
    logic [31:0]      fill_val;

    modport master (
        input  start, src, dst, len, bus_rd, fill, fill_val,
        output busy, done, bus_we, bus_addr, bus_wd
    );
    modport slave (
        output start, src, dst, len, bus_rd, fill, fill_val,
        input  busy, done, bus_we, bus_addr, bus_wd
    );
`else
    modport master (
        input  start, src, dst, len, bus_rd,
        output busy, done, bus_we, bus_addr, bus_wd
    );
    modport slave (
        output start, src, dst, len, bus_rd,
        input  busy, done, bus_we, bus_addr, bus_wd
    );
`endif
endinterface

// File: rtl/bus_dma.sv
// bus_dma: bus initiator that copies len 32-bit words from src to dst.
// Each word takes three cycles: READ (address out), WAIT (registered read
// data returns and is captured), WRITE (write committed at closing edge).
// All outputs are registered.
// Ports:
//   clk  - clock, posedge
//   rst  - synchronous active-high reset
//   bif  - bus_dma_if.master: start/src/dst/len request, busy/done status,
//          bus_we/bus_addr/bus_wd/bus_rd memory bus
// Optional feature macro: BUS_DMA_FILL_EN - adds fill/fill_val; a fill
// request skips READ/WAIT and writes fill_val to one word per cycle.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    bus_dma_if.master  bif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [LEN_W-1:0] REM_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] REM_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e           state_q,   state_d;
    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0] rem_q,     rem_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             we_q,      we_d;
    logic [31:0]      addr_q,    addr_d;
    logic [31:0]      wd_q,      wd_d;
    logic             fill_mode_s;

`ifdef BUS_DMA_FILL_EN
    logic             fill_q,    fill_d;
    assign fill_mode_s = fill_q;
`else
    assign fill_mode_s = 1'b0;
`endif

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = done_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
`ifdef BUS_DMA_FILL_EN
        fill_d    = fill_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bif.start) begin
                    if (bif.len != REM_ZERO) begin
                        src_ptr_d = word_align(bif.src);
                        dst_ptr_d = word_align(bif.dst);
                        rem_d     = bif.len;
                        busy_d    = 1'b1;
`ifdef BUS_DMA_FILL_EN
                        fill_d    = bif.fill;
                        if (bif.fill) begin
                            // Fill skips the read phase: first write goes out now.
                            wd_d    = bif.fill_val;
                            addr_d  = word_align(bif.dst);
                            we_d    = 1'b1;
                            state_d = S_WRITE;
                        end else begin
                            addr_d  = word_align(bif.src);
                            we_d    = 1'b0;
                            state_d = S_READ;
                        end
`else
                        addr_d    = word_align(bif.src);
                        we_d      = 1'b0;
                        state_d   = S_READ;
`endif
                    end else begin
                        // Zero-length request completes with no bus activity.
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Responder registers its read data, so it is valid only now.
                wd_d    = bif.bus_rd;
                addr_d  = dst_ptr_q;
                we_d    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                src_ptr_d = src_ptr_q + WORD_STEP;
                dst_ptr_d = dst_ptr_q + WORD_STEP;
                rem_d     = rem_q - REM_ONE;
                if (rem_q == REM_ONE) begin
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    addr_d  = 32'd0;
                    state_d = S_DONE;
                end else if (fill_mode_s) begin
                    // Back-to-back fill writes: keep we high, step destination.
                    we_d    = 1'b1;
                    addr_d  = dst_ptr_q + WORD_STEP;
                    state_d = S_WRITE;
                end else begin
                    we_d    = 1'b0;
                    addr_d  = src_ptr_q + WORD_STEP;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                we_d    = 1'b0;
                addr_d  = 32'd0;
                wd_d    = 32'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointer and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            src_ptr_q <= 32'd0;
            dst_ptr_q <= 32'd0;
            rem_q     <= REM_ZERO;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wd_q      <= 32'd0;
`ifdef BUS_DMA_FILL_EN
            fill_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
`ifdef BUS_DMA_FILL_EN
            fill_q    <= fill_d;
`endif
        end
    end

    assign bif.busy     = busy_q;
    assign bif.done     = done_q;
    assign bif.bus_we   = we_q;
    assign bif.bus_addr = addr_q;
    assign bif.bus_wd   = wd_q;

endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: self-checking bench for bus_dma. A behavioural RAM with
// registered read (plus the io registers at 0x0/0x4) sits on the bus.
// Each transfer is expanded by a word-by-word reference copy into an
// expected write list; a negedge monitor pops and compares every bus write.
module tb_bus_dma;
    import bus_dma_pkg::*;

    localparam int LEN_W = 16;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_dma_if #(.LEN_W(LEN_W)) bif ();

    bus_dma #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    wr_t exp_q[$];

    logic [31:0] mem      [0:4095];
    logic        written  [0:4095];
    logic [31:0] ref_mem  [0:4095];
    logic [31:0] io_in;
    logic [31:0] io_out;
    logic [31:0] rd_q;

    function automatic logic [31:0] seed_val(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [11:0] widx(input logic [31:0] a);
        logic [31:0] t;
        t = a >> 2;
        return t[11:0];
    endfunction

    function automatic logic [31:0] ram_read(input logic [31:0] a);
        if (a == IO_IN_ADDR) return io_in;
        else if (written[widx(a)]) return mem[widx(a)];
        else return seed_val(a & 32'h0000_3FFC);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (a == IO_IN_ADDR) return io_in;
        else return ref_mem[widx(a)];
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Behavioural RAM: registered read, write committed at the edge.
    initial begin
        for (int i = 0; i < 4096; i++) written[i] = 1'b0;
    end
    always @(posedge clk) begin
        rd_q <= ram_read(bif.bus_addr & 32'hFFFF_FFFC);
        if (bif.bus_we && !rst) begin
            mem[widx(bif.bus_addr)]     <= bif.bus_wd;
            written[widx(bif.bus_addr)] <= 1'b1;
            if ((bif.bus_addr & 32'hFFFF_FFFC) == IO_OUT_ADDR) io_out <= bif.bus_wd;
        end
    end
    assign bif.bus_rd = rd_q;

    // Monitor: every bus write must match the head of the expected list.
    always @(negedge clk) begin
        if (!rst && bif.bus_we) begin
            we_cnt <= we_cnt + 1;
            if (exp_q.size() == 0) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_write actual=%h required=none", bif.bus_addr);
            end else begin
                chk("wr_addr", bif.bus_addr, exp_q[0].a);
                chk("wr_data", bif.bus_wd,   exp_q[0].d);
                void'(exp_q.pop_front());
            end
        end
    end

    // Drive one request and check latency, busy width, done pulse, write count.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                            input logic f, input logic [31:0] fv, input int poke_at);
        int lat_exp, edges, busy_cnt, base;
        logic got;
        logic [31:0] sa, da, v;
        lat_exp = (n == 0) ? 1 : (f ? n + 1 : 3 * n + 1);
        for (int i = 0; i < n; i++) begin
            sa = (s & 32'hFFFF_FFFC) + 32'(4 * i);
            da = (d & 32'hFFFF_FFFC) + 32'(4 * i);
            v  = f ? fv : ref_read(sa);
            ref_mem[widx(da)] = v;
            exp_q.push_back('{a: da, d: v});
        end
        base = we_cnt;
        @(negedge clk);
        bif.start = 1'b1;
        bif.src   = s;
        bif.dst   = d;
        bif.len   = LEN_W'(n);
`ifdef BUS_DMA_FILL_EN
        bif.fill     = f;
        bif.fill_val = fv;
`endif
        @(posedge clk);
        #1 bif.start = 1'b0;
        edges = 1; busy_cnt = 0; got = 1'b0;
        while (!got && edges <= lat_exp + 8) begin
            @(negedge clk);
            if (bif.busy) busy_cnt++;
            if (bif.done) begin
                got = 1'b1;
            end else begin
                if (edges == poke_at) begin
                    bif.start = 1'b1;
                    bif.src   = s + 32'h40;
                    bif.len   = LEN_W'(n + 3);
                end
                @(posedge clk);
                #1 bif.start = 1'b0;
                edges++;
            end
        end
        chk("done_seen",   32'(got),      32'd1);
        chk("latency",     32'(edges),    32'(lat_exp));
        chk("busy_cycles", 32'(busy_cnt), 32'(lat_exp - 1));
        @(posedge clk);
        @(negedge clk);
        chk("done_width",  32'(bif.done),       32'd0);
        chk("we_count",    32'(we_cnt - base),  32'(n));
        chk("sb_drained",  32'(exp_q.size()),   32'd0);
    endtask

    // Reset during the second write of a len=4 copy.
    task automatic run_reset_mid;
        int edges, done_cnt, base;
        logic [31:0] sa, v;
        base = we_cnt;
        for (int i = 0; i < 2; i++) begin
            sa = 32'h500 + 32'(4 * i);
            v  = ref_read(sa);
            if (i == 0) ref_mem[widx(32'h600)] = v;
            exp_q.push_back('{a: 32'h600 + 32'(4 * i), d: v});
        end
        @(negedge clk);
        bif.start = 1'b1; bif.src = 32'h500; bif.dst = 32'h600; bif.len = LEN_W'(4);
        @(posedge clk);
        #1 bif.start = 1'b0;
        for (edges = 1; edges < 6; edges++) @(posedge clk);
        @(negedge clk);
        chk("we_before_rst", 32'(bif.bus_we), 32'd1);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_we",   32'(bif.bus_we), 32'd0);
        chk("rst_busy", 32'(bif.busy),   32'd0);
        chk("rst_done", 32'(bif.done),   32'd0);
        chk("rst_addr", bif.bus_addr,    32'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bif.done || bif.busy) done_cnt++;
        end
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        chk("rst_we_count", 32'(we_cnt - base), 32'd2);
        chk("rst_sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] s, d;
        int busy_seen;
        for (int i = 0; i < 4096; i++) ref_mem[i] = seed_val(32'(i * 4));
        io_in = 32'h1111_2222;
        rst = 1'b1;
        bif.start = 1'b0; bif.src = 32'd0; bif.dst = 32'd0; bif.len = '0;
`ifdef BUS_DMA_FILL_EN
        bif.fill = 1'b0; bif.fill_val = 32'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(bif.busy),   32'd0);
        chk("reset_done", 32'(bif.done),   32'd0);
        chk("reset_we",   32'(bif.bus_we), 32'd0);
        chk("reset_addr", bif.bus_addr,    32'd0);
        chk("reset_wd",   bif.bus_wd,      32'd0);

        // rst wins over start on the same edge.
        bif.start = 1'b1; bif.src = 32'h100; bif.dst = 32'h800; bif.len = LEN_W'(3);
        @(posedge clk);
        #1 bif.start = 1'b0; rst = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bif.busy || bif.bus_we) busy_seen++;
        end
        chk("rst_over_start", 32'(busy_seen), 32'd0);

        // Directed cases.
        run_xfer(32'h100, 32'h200, 3, 1'b0, 32'd0, 0);
        chk("abc_word0", ram_read(32'h200), ref_read(32'h100));
        chk("abc_word2", ram_read(32'h208), ref_read(32'h108));
        run_xfer(32'h140, 32'h240, 0, 1'b0, 32'd0, 0);
        run_xfer(32'h180, 32'h280, 2, 1'b0, 32'd0, 2);
        run_reset_mid();
        run_xfer(32'hFFFF_FFFC, 32'h10, 2, 1'b0, 32'd0, 0);
        io_in = 32'hCAFE_BABE;
        run_xfer(IO_IN_ADDR, IO_OUT_ADDR, 1, 1'b0, 32'd0, 0);
        chk("io_out", io_out, 32'hCAFE_BABE);
`ifdef BUS_DMA_FILL_EN
        run_xfer(32'h0, 32'h300, 4, 1'b1, 32'h5A5A_5A5A, 0);
        chk("fill_word3", ram_read(32'h30C), 32'h5A5A_5A5A);
`endif

        // Randomized copies, ranges may overlap (forward copy semantics).
        for (int k = 0; k < 10; k++) begin
            s = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            d = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            run_xfer(s, d, int'($urandom_range(0, 6)), 1'b0, 32'd0, 0);
        end

        // Whole-memory comparison against the reference image.
        for (int i = 2; i < 4096; i++) begin
            if (ram_read(32'(i * 4)) !== ref_mem[i]) chk("mem_image", ram_read(32'(i * 4)), ref_mem[i]);
        end
        chk("mem_image_total", ram_read(32'h204), ref_mem[widx(32'h204)]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_dma.md
Name: bus_dma

Overview:
- Bus initiator that copies a block of 32-bit words from a source address range to a destination range.
- Drives the shared memory-mapped data bus (we/addr/wd out, rd in). Read data is registered by the responder: data is valid one cycle after the address is presented.
- Sits beside the CPU load/store path. A mux outside this block selects the bus owner.

Parameters:
LEN_W, 16, width of the word-count input and the internal remaining-count register.

Ports:
clk  in  1  clock; all logic is on the posedge.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle request. Accepted only in IDLE.
src  in  32  source byte address. Bits [1:0] are ignored and treated as 00.
dst  in  32  destination byte address. Bits [1:0] are ignored and treated as 00.
len  in  LEN_W  number of words to copy.
busy  out  1  high while a transfer is in progress.
done  out  1  one-cycle pulse when a transfer completes.
bus_we  out  1  bus write enable.
bus_addr  out  32  bus byte address.
bus_wd  out  32  bus write data.
bus_rd  in  32  bus read data; valid the cycle after bus_addr is presented.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, bus_we=0, bus_addr=0, bus_wd=0. State=IDLE.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - On start with len!=0: latch src/dst/len into pointers and remaining count, then go to READ. Drive bus_addr=src_ptr, bus_we=0, busy=1.
  - On start with len==0: go directly to DONE. No bus activity.
  - start is ignored in every state other than IDLE, including DONE.
- READ: bus_addr=src_ptr is on the bus for this cycle. Go to WAIT.
- WAIT: bus_rd now holds mem[src_ptr]. At the edge:
  - capture bus_rd into bus_wd;
  - set bus_addr=dst_ptr and bus_we=1;
  - go to WRITE.
- WRITE: the write commits at the closing edge. At that edge:
  - bus_we<=0;
  - src_ptr+=4 and dst_ptr+=4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000);
  - remaining-=1.
  - If remaining was 1, go to DONE: busy<=0, done<=1, bus_addr<=0.
  - Otherwise go to READ with bus_addr=new src_ptr.
- DONE: done is high for exactly this one cycle, then go to IDLE with done<=0.
- Throughput: 3 cycles per word.
  - Latency from the start edge to the done pulse is 3*len+1 cycles.
  - For len==0 it is 1 cycle.
- bus_we is high only in WRITE, for exactly one cycle per word.
- Overlapping ranges: the copy is forward-only. No overlap correction.
- Reset mid-transfer: at the next edge, return to IDLE with all outputs at reset values. A write in progress is dropped and no done pulse is issued.
- rst takes priority over start on the same edge.

Optional Feature:
Macro BUS_DMA_FILL_EN.
- Defined:
  - Adds ports fill (in, 1) and fill_val (in, 32), both sampled with start.
  - When fill=1, READ and WAIT are skipped. The FSM goes IDLE -> WRITE with bus_wd=fill_val, and each subsequent word goes WRITE -> WRITE.
  - Throughput is 1 cycle per word, bus_we stays high for len consecutive cycles, and dst_ptr steps by 4 each cycle.
  - src is ignored.
- Undefined: the ports are absent and behaviour is copy-only as above.

Decomposition:
- Shared consts include holds:
  - bus word-step constant (4);
  - IO map addresses: IO_IN_ADDR=0x0000_0000, IO_OUT_ADDR=0x0000_0004.
- FSM state encodings are localparams inside the module.
- Single module; no sub-module needed.

Test Plan:
- Behavioural RAM with 1-cycle registered read; mem[0x100..0x108]=A,B,C. Stimulus: start with src=0x100, dst=0x200, len=3 -> mem[0x200..0x208]=A,B,C; exactly 3 bus_we pulses; done 10 cycles after start; busy high for 9 cycles.
- Stimulus: len=0 -> done the cycle after start; bus_we never asserted; busy stays 0.
- Stimulus: second start (different src) pulsed during WAIT of a len=2 transfer -> ignored; only the original 2 words are copied.
- Stimulus: rst asserted during the WRITE of word 2 of a len=4 transfer -> next cycle bus_we=0, busy=0, state IDLE, no done; words 3 and 4 are not written.
- Stimulus: src=0xFFFF_FFFC, dst=0x10, len=2 -> reads 0xFFFF_FFFC then 0x0000_0000.
- Connect to the io responder: io_in=0xCAFEBABE, src=0x0, dst=0x4, len=1 -> io_out=0xCAFEBABE after done.
- With BUS_DMA_FILL_EN defined: fill=1, fill_val=0x5A5A5A5A, dst=0x300, len=4 -> 4 consecutive bus_we cycles; mem[0x300..0x30C] all 0x5A5A5A5A; done 5 cycles after start.
